// File: rtl/ghash_seq.sv
// GHASH input sequencer: merges AAD, ciphertext and the final length block into
// one zero-padded 128-bit stream behind a single-entry valid/ready output register.
module ghash_seq #(
  parameter int CNT_W = 16,
  parameter int LEN_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] aad_total,
  input  logic [CNT_W-1:0] ct_total,
  input  logic [127:0]     aad_in,
  input  logic [4:0]       aad_byte_len,
  input  logic             aad_valid,
  output logic             aad_ready,
  input  logic [127:0]     ct_in,
  input  logic [4:0]       ct_byte_len,
  input  logic             ct_valid,
  output logic             ct_ready,
  output logic [127:0]     ghash_data,
  output logic             ghash_valid,
  output logic             ghash_last,
  input  logic             ghash_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {S_IDLE, S_AAD, S_CT, S_LEN, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   aad_tot_q, aad_tot_d;
  logic [CNT_W-1:0]   ct_tot_q, ct_tot_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   aad_bits_q, aad_bits_d;
  logic [LEN_W-1:0]   ct_bits_q, ct_bits_d;
  logic [127:0]       data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               done_q, done_d;
  logic               loadable;

  function automatic logic [4:0] eff_len(input logic [4:0] bl);
    return (bl == 5'd0 || bl >= 5'd16) ? 5'd16 : bl;
  endfunction

  function automatic logic [127:0] pad(input logic [127:0] d, input logic [4:0] bl);
    int sh;
    sh = 8 * (16 - int'(eff_len(bl)));
    return d & ({128{1'b1}} << sh);
  endfunction

  function automatic logic [LEN_W-1:0] bits_of(input logic [4:0] bl);
    return LEN_W'({eff_len(bl), 3'b000});
  endfunction

  always_comb begin
    state_d    = state_q;
    aad_tot_d  = aad_tot_q;
    ct_tot_d   = ct_tot_q;
    cnt_d      = cnt_q;
    aad_bits_d = aad_bits_q;
    ct_bits_d  = ct_bits_q;
    data_d     = data_q;
    last_d     = last_q;
    done_d     = 1'b0;
    aad_ready  = 1'b0;
    ct_ready   = 1'b0;
    loadable   = !valid_q || ghash_ready;
    valid_d    = valid_q && !ghash_ready;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          aad_tot_d  = aad_total;
          ct_tot_d   = ct_total;
          cnt_d      = '0;
          aad_bits_d = '0;
          ct_bits_d  = '0;
          if (aad_total != '0)     state_d = S_AAD;
          else if (ct_total != '0) state_d = S_CT;
          else begin
            // Empty message: the all-zero length block goes out immediately.
            data_d  = '0;
            valid_d = 1'b1;
            last_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_AAD: begin
        aad_ready = loadable;
        if (aad_valid && loadable) begin
          data_d     = pad(aad_in, aad_byte_len);
          valid_d    = 1'b1;
          last_d     = 1'b0;
          aad_bits_d = aad_bits_q + bits_of(aad_byte_len);
          if (cnt_q == aad_tot_q - CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = (ct_tot_q != '0) ? S_CT : S_LEN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_CT: begin
        ct_ready = loadable;
        if (ct_valid && loadable) begin
          data_d    = pad(ct_in, ct_byte_len);
          valid_d   = 1'b1;
          last_d    = 1'b0;
          ct_bits_d = ct_bits_q + bits_of(ct_byte_len);
          if (cnt_q == ct_tot_q - CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = S_LEN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_LEN: begin
        if (loadable) begin
          data_d  = {64'(aad_bits_q), 64'(ct_bits_q)};
          valid_d = 1'b1;
          last_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (valid_q && ghash_ready) begin
          done_d  = 1'b1;
          last_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      aad_tot_q  <= '0;
      ct_tot_q   <= '0;
      cnt_q      <= '0;
      aad_bits_q <= '0;
      ct_bits_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      aad_tot_q  <= aad_tot_d;
      ct_tot_q   <= ct_tot_d;
      cnt_q      <= cnt_d;
      aad_bits_q <= aad_bits_d;
      ct_bits_q  <= ct_bits_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      done_q     <= done_d;
    end
  end

  assign ghash_data  = data_q;
  assign ghash_valid = valid_q;
  assign ghash_last  = last_q;
  assign done        = done_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_ghash_seq.sv
// Directed + randomized bench for ghash_seq against a byte-level GCM ordering model.
module tb_ghash_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [15:0]  aad_total, ct_total;
  logic [127:0] aad_in, ct_in;
  logic [4:0]   aad_byte_len, ct_byte_len;
  logic         aad_valid, ct_valid, ghash_ready;
  logic         aad_ready, ct_ready, ghash_valid, ghash_last, busy, done;
  logic [127:0] ghash_data;

  int passed = 0;
  int total  = 0;

  logic [127:0] aad_blk[8];
  int           aad_len[8];
  logic [127:0] ct_blk[8];
  int           ct_len[8];
  logic [127:0] len_seen;

  always #5 clk = ~clk;

  ghash_seq #(.CNT_W(16), .LEN_W(64)) dut (
    .clk(clk), .rst(rst), .start(start), .aad_total(aad_total), .ct_total(ct_total),
    .aad_in(aad_in), .aad_byte_len(aad_byte_len), .aad_valid(aad_valid), .aad_ready(aad_ready),
    .ct_in(ct_in), .ct_byte_len(ct_byte_len), .ct_valid(ct_valid), .ct_ready(ct_ready),
    .ghash_data(ghash_data), .ghash_valid(ghash_valid), .ghash_last(ghash_last),
    .ghash_ready(ghash_ready), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int eff(input int bl);
    return (bl == 0 || bl >= 16) ? 16 : bl;
  endfunction

  // Bytes past the valid length are zero; byte 0 is the most significant.
  function automatic logic [127:0] m_pad(input logic [127:0] d, input int bl);
    logic [127:0] r;
    r = d;
    for (int b = 0; b < 16; b++)
      if (b >= eff(bl)) r[127-8*b -: 8] = 8'h00;
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // rmode: 0 ready always high, 1 ready pattern 1,0,0, 2 random.
  task automatic run(input int na, input int nc, input int rmode, input bit restart,
                     input bit abort, output logic [127:0] last_out);
    logic [127:0] exp_q[$];
    logic [63:0]  as, cs;
    logic [127:0] held;
    logic         held_last, was_stall, got_done;
    int ai, ci, oi;
    as = 0; cs = 0;
    for (int i = 0; i < na; i++) begin
      exp_q.push_back(m_pad(aad_blk[i], aad_len[i]));
      as += 64'(8 * eff(aad_len[i]));
    end
    for (int i = 0; i < nc; i++) begin
      exp_q.push_back(m_pad(ct_blk[i], ct_len[i]));
      cs += 64'(8 * eff(ct_len[i]));
    end
    exp_q.push_back({as, cs});
    last_out = 'x;

    @(negedge clk);
    start = 1'b1; aad_total = 16'(na); ct_total = 16'(nc); ghash_ready = 1'b1;
    aad_valid = (na > 0); aad_in = aad_blk[0]; aad_byte_len = 5'(aad_len[0]);
    ct_valid = (nc > 0); ct_in = ct_blk[0]; ct_byte_len = 5'(ct_len[0]);
    #1 chk("idle_no_ready", {126'd0, aad_ready, ct_ready}, 128'd0);
    @(negedge clk);
    start = 1'b0;
    #1 chk("busy_after_start", {127'd0, busy}, 128'd1);
    if (na == 0 && nc == 0) begin
      chk("empty_len_valid", {126'd0, ghash_valid, ghash_last}, 128'd3);
      chk("empty_len_data", ghash_data, 128'd0);
    end

    ai = 0; ci = 0; oi = 0; got_done = 0; was_stall = 0; held = '0; held_last = 0;
    for (int cyc = 0; cyc < 600 && !got_done; cyc++) begin
      if (abort && ci == 1) begin
        rst = 1'b0;
        #1;
        chk("abort_outs", {122'd0, ghash_valid, ghash_last, busy, done, aad_ready, ct_ready}, 128'd0);
        chk("abort_data", ghash_data, 128'd0);
        aad_valid = 0; ct_valid = 0;
        #2 rst = 1'b1;
        @(negedge clk);
        #1 chk("abort_no_done", {126'd0, done, busy}, 128'd0);
        return;
      end
      aad_valid    = (ai < na) && (rmode != 2 || $urandom_range(3) != 0);
      aad_in       = aad_blk[ai < na ? ai : 0];
      aad_byte_len = 5'(aad_len[ai < na ? ai : 0]);
      ct_valid     = (ci < nc) && (rmode != 2 || $urandom_range(3) != 0);
      ct_in        = ct_blk[ci < nc ? ci : 0];
      ct_byte_len  = 5'(ct_len[ci < nc ? ci : 0]);
      ghash_ready  = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(1));
      start        = restart && (cyc == 4);
      aad_total    = start ? 16'd7 : 16'(na);
      ct_total     = start ? 16'd5 : 16'(nc);
      #1;
      chk("one_ready", {127'd0, aad_ready && ct_ready}, 128'd0);
      if (ghash_valid && !ghash_ready)
        chk("stall_ready_low", {126'd0, aad_ready, ct_ready}, 128'd0);
      if (was_stall) begin
        chk("stall_data_hold", ghash_data, held);
        chk("stall_last_hold", {127'd0, ghash_last}, {127'd0, held_last});
      end
      was_stall = ghash_valid && !ghash_ready;
      held = ghash_data; held_last = ghash_last;
      if (done) begin
        got_done = 1;
        chk("done_after_all", 128'(oi), 128'(exp_q.size()));
      end
      if (ghash_valid && ghash_ready) begin
        if (oi < exp_q.size()) begin
          chk("out_block", ghash_data, exp_q[oi]);
          chk("out_last", {127'd0, ghash_last}, {127'd0, oi == exp_q.size() - 1});
        end else chk("extra_out", 128'(oi), 128'(exp_q.size() - 1));
        last_out = ghash_data;
        oi++;
      end
      if (aad_valid && aad_ready) ai++;
      if (ct_valid && ct_ready) ci++;
      @(negedge clk);
    end
    chk("done_seen", {127'd0, got_done}, 128'd1);
    aad_valid = 0; ct_valid = 0; start = 0; ghash_ready = 1;
    #1 chk("post_done_idle", {125'd0, done, busy, ghash_valid}, 128'd0);
  endtask

  task automatic fill_spec();
    aad_blk[0] = 128'hfeedfacedeadbeeffeedfacedeadbeef; aad_len[0] = 16;
    aad_blk[1] = {32'habaddad2, $urandom, $urandom, $urandom};  aad_len[1] = 4;
    for (int i = 0; i < 4; i++) begin ct_blk[i] = rnd128(); ct_len[i] = 16; end
    ct_len[3] = 12;
  endtask

  initial begin
    rst = 1'b0; start = 0; aad_total = 0; ct_total = 0; aad_in = 0; ct_in = 0;
    aad_byte_len = 0; ct_byte_len = 0; aad_valid = 0; ct_valid = 0; ghash_ready = 0;
    for (int i = 0; i < 8; i++) begin
      aad_blk[i] = rnd128(); aad_len[i] = 16; ct_blk[i] = rnd128(); ct_len[i] = 16;
    end
    #12;
    chk("reset_outs", {123'd0, ghash_valid, ghash_last, busy, done, aad_ready}, 128'd0);
    chk("reset_data", ghash_data, 128'd0);
    rst = 1'b1;

    fill_spec();
    run(2, 4, 0, 0, 0, len_seen);
    chk("spec_len_block", len_seen, {64'h00000000000000a0, 64'h00000000000001e0});

    ct_blk[0] = rnd128(); ct_len[0] = 16;
    run(0, 1, 0, 0, 0, len_seen);
    chk("ct_only_len", len_seen, {64'd0, 64'h80});

    run(0, 0, 0, 0, 0, len_seen);
    chk("empty_len", len_seen, 128'd0);

    fill_spec();
    run(2, 4, 1, 0, 0, len_seen);
    chk("stall_len_block", len_seen, {64'h00000000000000a0, 64'h00000000000001e0});

    run(2, 4, 0, 1, 0, len_seen);
    chk("restart_len_block", len_seen, {64'h00000000000000a0, 64'h00000000000001e0});

    run(2, 4, 0, 0, 1, len_seen);
    ct_len[0] = 0; ct_len[1] = 20; ct_len[2] = 1;
    run(1, 3, 2, 0, 0, len_seen);
    chk("fresh_len_block", len_seen, {64'h80, 64'd264});

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 8; i++) begin
        aad_blk[i] = rnd128(); aad_len[i] = $urandom_range(31);
        ct_blk[i]  = rnd128(); ct_len[i]  = $urandom_range(31);
      end
      run($urandom_range(4), $urandom_range(5), 2, 0, 0, len_seen);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ghash_seq.md
Name: ghash_seq

Overview:
- Sequencer between the CTR encryption datapath and the GHASH split multiplier.
- Merges three streams into one 128-bit GHASH input stream, in strict GCM order:
  - AAD blocks,
  - ciphertext (CText) blocks,
  - the final len(A)||len(C) block.
- Zero-pads partial final blocks and accumulates bit lengths.
- Gives the multiplier a single-register valid/ready interface with backpressure.

Parameters:
- CNT_W, 16: width of the block-count inputs and internal block counters.
- LEN_W, 64: width of each bit-length accumulator; matches the GCM length-field width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle pulse; latches aad_total and ct_total. Ignored unless the block is idle.
- aad_total  in  CNT_W  number of AAD blocks. 0 is legal.
- ct_total  in  CNT_W  number of CText blocks. 0 is legal.
- aad_in  in  128  AAD block, byte 0 = bits [127:120].
- aad_byte_len  in  5  valid bytes in aad_in.
- aad_valid  in  1  aad_in is valid.
- aad_ready  out  1  aad_in is accepted when aad_valid && aad_ready.
- ct_in  in  128  CText block.
- ct_byte_len  in  5  valid bytes in ct_in.
- ct_valid  in  1  ct_in is valid.
- ct_ready  out  1  ct_in is accepted when ct_valid && ct_ready.
- ghash_data  out  128  padded block to the multiplier.
- ghash_valid  out  1  ghash_data is valid.
- ghash_last  out  1  marks the length block.
- ghash_ready  in  1  multiplier accepts the block.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the length block is accepted.

Behaviour:
- Reset (asynchronous, rst=0): all outputs go to 0, state=IDLE, counters and accumulators cleared. Reset asserted mid-operation aborts the operation; no done pulse is produced.
- States and transitions:
  - IDLE: on start, go to AAD if aad_total≠0, else CT if ct_total≠0, else LEN.
  - AAD: accept exactly aad_total blocks, then go to CT (or LEN if ct_total=0).
  - CT: accept ct_total blocks, then go to LEN.
  - LEN: load the length block into the output register, then go to WAIT.
  - WAIT: when the length block is accepted, pulse done and return to IDLE.
- Output register (single entry):
  - Loadable when !ghash_valid || ghash_ready.
  - aad_ready = (state==AAD) && loadable; ct_ready = (state==CT) && loadable.
  - Never more than one ready is high.
  - Throughput: one block per cycle when ghash_ready is held high.
  - Latency: an input accepted at edge N is presented on ghash_data/ghash_valid after edge N.
  - While ghash_valid && !ghash_ready, ghash_data and ghash_last hold stable.
  - ghash_valid deasserts after acceptance unless a new block is loaded in the same cycle.
- Byte-length rules:
  - byte_len 0 or ≥16 is treated as 16.
  - For effective length L, bytes L..15 are forced to 0: bits [127-8L:0] cleared.
  - The accumulator adds 8·L bits per accepted block (aad_bits or ct_bits).
  - Accumulators wrap modulo 2^LEN_W; no saturation.
- Length block: ghash_data = {aad_bits, ct_bits}, each right-aligned in 64 bits; ghash_last=1 for this block only.
- start while busy: ignored; totals are not relatched.
- start and an input valid in the same cycle: the input is not accepted, because ready is 0 in IDLE.
- Block counts are counted on accepted handshakes only; the counter compares against the latched total minus 1.
- done and the return to IDLE happen on the same edge, so a start on the next cycle is accepted.

Test Plan:
- AAD 2 blocks (feedfacedeadbeeffeedfacedeadbeef, abaddad2… with len 4) and CT 4 blocks (last len 12), ghash_ready=1 → 7 back-to-back outputs. Block 2 = abaddad2 followed by 12 zero bytes; block 6 has its low 4 bytes zeroed; last = 00000000000000a0_00000000000001e0 with ghash_last=1; done pulses once.
- aad_total=0, ct_total=1 (16 bytes) → only the CT block, then length block 0…0_0000000000000080.
- aad_total=0, ct_total=0 → length block all-zero on the cycle after start, then done.
- Same run as scenario 1 with ghash_ready toggled 1,0,0,1… → ghash_data stable while stalled; aad_ready/ct_ready low while stalled; identical output sequence.
- Second start mid-run → ignored, sequence unchanged. rst=0 during the CT phase → all outputs 0 immediately; a fresh start completes normally with fresh lengths.
